// File: rtl/uart_tx_param_if.sv
// Valid/ready word handshake between a byte source
// and the parametrised UART transmitter.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, LSB-first data,
// optional parity, 1 or 2 stop bits; registered outputs.
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_param_if.slave  bus,
  output logic            tx,
  output logic            busy,
  output logic            done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
  localparam logic PEN = (PARITY_EN != 0);
  localparam logic ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        idx, idx_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic                 par, par_n;
  logic                 rdy, rdy_n;
  logic                 tx_n, busy_n, done_n;
  logic                 last;

  assign bus.tx_ready = rdy;
  assign last = (cnt == CNT_MAX);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Datapath and output registers; reset parks the line high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      idx  <= '0;
      sh   <= '0;
      par  <= 1'b0;
      tx   <= 1'b1;
      rdy  <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      cnt  <= cnt_n;
      idx  <= idx_n;
      sh   <= sh_n;
      par  <= par_n;
      tx   <= tx_n;
      rdy  <= rdy_n;
      busy <= busy_n;
      done <= done_n;
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    sh_n    = sh;
    par_n   = par;
    tx_n    = tx;
    rdy_n   = 1'b0;
    busy_n  = 1'b1;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n  = '0;
        idx_n  = '0;
        tx_n   = 1'b1;
        rdy_n  = 1'b1;
        busy_n = 1'b0;
        if (bus.tx_valid && rdy) begin
          state_n = START;
          sh_n    = bus.tx_data;
          par_n   = (^bus.tx_data) ^ ODD;
          tx_n    = 1'b0;
          rdy_n   = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (last) begin
          state_n = DATA;
          cnt_n   = '0;
          idx_n   = '0;
          tx_n    = sh[0];
        end
      end
      DATA: begin
        if (last) begin
          cnt_n = '0;
          if (idx == IDX_LAST) begin
            idx_n = '0;
            if (PEN) begin
              state_n = PARITY;
              tx_n    = par;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            idx_n = idx + 1'b1;
            sh_n  = sh >> 1;
            tx_n  = sh[1];
          end
        end
      end
      PARITY: begin
        if (last) begin
          state_n = STOP;
          cnt_n   = '0;
          idx_n   = '0;
          tx_n    = 1'b1;
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (last) begin
          cnt_n = '0;
          if (idx == STOP_LAST) begin
            state_n = IDLE;
            idx_n   = '0;
            rdy_n   = 1'b1;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = '0;
        tx_n    = 1'b1;
        rdy_n   = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: 8N1, 7E1 and 7O2
// instances, all at 4 clocks per bit.
module tb_uart_tx_param;
  logic clk = 1'b0;
  logic rst;
  logic [8:0] d;
  logic v;
  int sel;
  int passed = 0;
  int failed = 0;
  int total = 0;
  int hs = 0;

  always #5 clk = ~clk;

  uart_tx_param_if #(.DATA_BITS(8)) b8 ();
  uart_tx_param_if #(.DATA_BITS(7)) b7e ();
  uart_tx_param_if #(.DATA_BITS(7)) b7o ();

  logic tx8, busy8, done8;
  logic tx7e, busy7e, done7e;
  logic tx7o, busy7o, done7o;

  assign b8.tx_data   = d[7:0];
  assign b7e.tx_data  = d[6:0];
  assign b7o.tx_data  = d[6:0];
  assign b8.tx_valid  = v && (sel == 0);
  assign b7e.tx_valid = v && (sel == 1);
  assign b7o.tx_valid = v && (sel == 2);

  uart_tx_param #(
    .CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0),
    .PARITY_ODD(0), .STOP_BITS(1)
  ) u8 (
    .clk(clk), .rst(rst), .bus(b8),
    .tx(tx8), .busy(busy8), .done(done8)
  );

  uart_tx_param #(
    .CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY_EN(1),
    .PARITY_ODD(0), .STOP_BITS(1)
  ) u7e (
    .clk(clk), .rst(rst), .bus(b7e),
    .tx(tx7e), .busy(busy7e), .done(done7e)
  );

  uart_tx_param #(
    .CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY_EN(1),
    .PARITY_ODD(1), .STOP_BITS(2)
  ) u7o (
    .clk(clk), .rst(rst), .bus(b7o),
    .tx(tx7o), .busy(busy7o), .done(done7o)
  );

  logic tx_o, busy_o, done_o, rdy_o;

  // Route the selected instance to the observation signals
  always_comb begin
    tx_o = tx8; busy_o = busy8;
    done_o = done8; rdy_o = b8.tx_ready;
    case (sel)
      1: begin
        tx_o = tx7e; busy_o = busy7e;
        done_o = done7e; rdy_o = b7e.tx_ready;
      end
      2: begin
        tx_o = tx7o; busy_o = busy7o;
        done_o = done7o; rdy_o = b7o.tx_ready;
      end
      default: ;
    endcase
  end

  // Count handshakes on the selected instance
  always @(posedge clk) begin
    if (v && rdy_o) hs = hs + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [8:0] obs,
                     input logic [8:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [8:0] data,
                      input bit keep);
    int w = 0;
    d = data;
    v = 1'b1;
    while (rdy_o !== 1'b1 && w < 100) begin
      tick();
      w++;
    end
    chk("ready_wait", rdy_o, 1);
    tick();
    if (!keep) v = 1'b0;
  endtask

  task automatic frame(input logic [8:0] data,
                       input int nb, input int pen,
                       input logic pb, input int ns,
                       input bit tog);
    int n = (1 + nb + pen + ns) * 4;
    int b;
    logic e;
    for (int k = 0; k < n; k++) begin
      b = k / 4;
      if (b == 0) e = 1'b0;
      else if (b <= nb) e = data[b-1];
      else if (pen != 0 && b == nb + 1) e = pb;
      else e = 1'b1;
      chk($sformatf("tx@%0d", k), tx_o, e);
      chk($sformatf("busy@%0d", k), busy_o, 1);
      chk($sformatf("done@%0d", k), done_o, 0);
      if (tog) d = ~d;
      tick();
    end
    chk("done_end", done_o, 1);
    chk("busy_end", busy_o, 0);
    chk("ready_end", rdy_o, 1);
    chk("tx_end", tx_o, 1);
  endtask

  // Directed stimulus sequence
  initial begin
    int hs0;
    rst = 1'b0; v = 1'b0; d = '0; sel = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_tx", tx_o, 1);
    chk("rst_ready", rdy_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    #10 rst = 1'b0;
    tick();
    repeat (3) begin
      chk("idle_tx", tx_o, 1);
      chk("idle_done", done_o, 0);
      tick();
    end

    sel = 0;
    send(9'h0A5, 0);
    frame(9'h0A5, 8, 0, 1'b0, 1, 0);
    tick();
    chk("a5_done_once", done_o, 0);

    sel = 1;
    send(9'h055, 0);
    frame(9'h055, 7, 1, 1'b0, 1, 0);
    tick();
    chk("even_done_once", done_o, 0);

    sel = 2;
    send(9'h055, 0);
    frame(9'h055, 7, 1, 1'b1, 2, 0);
    tick();
    chk("odd2_done_once", done_o, 0);

    sel = 0;
    tick();
    hs0 = hs;
    send(9'h000, 1);
    d = 9'h0FF;
    frame(9'h000, 8, 0, 1'b0, 1, 0);
    tick();
    v = 1'b0;
    chk("b2b_busy", busy_o, 1);
    frame(9'h0FF, 8, 0, 1'b0, 1, 0);
    tick();
    chk("b2b_handshakes", 9'(hs - hs0), 2);

    send(9'h00F, 0);
    repeat (17) tick();
    chk("mid_bit3", tx_o, 1);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_tx", tx_o, 1);
    chk("mid_rst_ready", rdy_o, 1);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_done", done_o, 0);
    #2 rst = 1'b0;
    tick();
    chk("post_rst_tx", tx_o, 1);
    chk("post_rst_busy", busy_o, 0);
    send(9'h03C, 0);
    frame(9'h03C, 8, 0, 1'b0, 1, 0);
    tick();

    send(9'h081, 0);
    frame(9'h081, 8, 0, 1'b0, 1, 1);
    tick();
    chk("tog_done_once", done_o, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
- Parametrised UART transmitter, next generation of the team's fixed 8N1 transmitter.
- Serialises one word per valid/ready handshake onto a single line.
- Configurable data width, optional even/odd parity and 1 or 2 stop bits.
- Reports busy and a one-cycle frame-done pulse; sits between a byte source (FIFO or control FSM) and the board TX pin.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per bit (100 MHz / 115200); legal ≥ 2.
- DATA_BITS, 8: data bits per frame; legal 5..9.
- PARITY_EN, 0: 1 = insert a parity bit after the data bits.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
- STOP_BITS, 1: number of stop bits; legal 1 or 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- tx_data  input  DATA_BITS  word to send; sampled only on handshake.
- tx_valid  input  1  source has a word.
- tx_ready  output  1  block can accept a word; high only in IDLE.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is in progress (not IDLE).
- done  output  1  one-cycle pulse at frame end.

Behaviour:
- Reset (async, immediate): tx = 1, tx_ready = 1, busy = 0, done = 0, state = IDLE, bit counter = 0, bit index = 0.
- Reset mid-frame abandons the frame; the line returns high with no glitch low.
- All outputs are registered.
- Handshake:
  - A word is accepted at a rising edge where tx_valid = 1 and tx_ready = 1.
  - On acceptance, tx_data is latched into a shift register and parity is computed from the latched value.
  - tx_data and tx_valid are don't-care while busy = 1.
- States: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE. Unreachable encodings return to IDLE.
- IDLE: tx = 1, tx_ready = 1, busy = 0. On handshake, go to START; after that edge tx = 0, tx_ready = 0, busy = 1.
- Bit timing: each state holds tx for exactly CLKS_PER_BIT cycles.
  - The cycle counter runs 0..CLKS_PER_BIT-1 and is $clog2(CLKS_PER_BIT) bits wide.
  - It clears on every bit transition.
- DATA: LSB first.
  - Bit index runs 0..DATA_BITS-1, with width sized for DATA_BITS.
  - After the last data bit, go to PARITY, or to STOP when parity is disabled.
- PARITY: tx = XOR of all latched data bits, inverted when PARITY_ODD = 1.
- STOP: tx = 1 for STOP_BITS × CLKS_PER_BIT cycles, then go to IDLE.
  - done = 1 for the first cycle after entering IDLE.
  - tx_ready = 1 and busy = 0 from that same cycle.
- Frame length: accept edge to done edge = N = (1 + DATA_BITS + PARITY_EN + STOP_BITS) × CLKS_PER_BIT cycles.
- Back-to-back: with tx_valid held high, the next handshake occurs in the done cycle.
  - The next start bit begins one cycle after done.
  - The line therefore stays high for STOP_BITS × CLKS_PER_BIT + 1 cycles between frames.
  - No frame is dropped or duplicated.
- done and a new handshake in the same cycle are legal.
- Words wider than DATA_BITS are impossible by construction. Only DATA_BITS bits are ever shifted.

Test Plan:
- Reset idle, CLKS_PER_BIT=4, 8N1: assert rst mid-cycle -> tx=1, tx_ready=1, busy=0, done=0 immediately; tx stays 1 with tx_valid=0.
- Single frame, 8N1, CLKS_PER_BIT=4, tx_data=8'hA5: the line holds 0 for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles; done pulses once 40 cycles after the accept edge.
- Parity, DATA_BITS=7, PARITY_EN=1:
  - even, tx_data=7'h55: parity bit = 0.
  - PARITY_ODD=1, same data: parity bit = 1.
  - 2 stop bits (STOP_BITS=2): stop high for 8 cycles; frame = 44 cycles.
- Back-to-back: tx_valid held high with 8'h00 then 8'hFF.
  - Exactly two handshakes occur; the second is in the done cycle.
  - There are 5 high cycles between the first stop start and the second start bit.
  - The decoded bytes match.
- Mid-frame reset during DATA bit 3 of 8'h0F: tx=1 asynchronously, state IDLE; a following 8'h3C frame decodes correctly.
- Data change during busy: tx_data toggles every cycle after accepting 8'h81 -> serialised bits still equal 8'h81.
